sbox_scheduler: RTL and testbench
=================================

Name: sbox_scheduler

Overview:
- Time-multiplexes a small pool of combinational AES S-box lookup instances between two requesters.
- Requester 1 is the round datapath: 128-bit SubBytes on the full state.
- Requester 2 is key expansion: 32-bit SubWord.
- Sits between the round controller / key-expansion unit and the S-box ROMs. It lets the core use LANES S-boxes instead of 20.

Parameters:
- LANES, 4: number of S-box instances, processed bytes per cycle. Legal values are 1, 2, 4, 8 and 16.
- ST_BEATS, 16/LANES: derived; cycles per state job.
- KW_BEATS, max(1, 4/LANES): derived; cycles per key-word job. When LANES>4, only lanes 0-3 are used for a key word.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- st_req_valid  in  1  state SubBytes request.
- st_req_ready  out  1  state request accepted this cycle when high together with st_req_valid.
- st_in  in  128  state to substitute; byte i = bits [127-8i:120-8i].
- st_out  out  128  substituted state, registered, same byte order as st_in.
- st_out_valid  out  1  one-cycle pulse: st_out holds a new result.
- kw_req_valid  in  1  key-word SubWord request.
- kw_req_ready  out  1  key-word request accepted when high together with kw_req_valid.
- kw_in  in  32  word to substitute; byte i = bits [31-8i:24-8i].
- kw_out  out  32  substituted word, registered.
- kw_out_valid  out  1  one-cycle pulse: kw_out holds a new result.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - FSM goes to IDLE; beat counter = 0.
  - st_out, kw_out and the internal result/shadow registers clear to 0.
  - st_out_valid, kw_out_valid and busy go to 0.
  - last_grant = ST, so the key word wins the first tie.
  - Reset mid-job discards the job silently; no out_valid is produced.
- FSM states: IDLE, RUN_ST, RUN_KW.
- IDLE ready and arbitration (combinational):
  - If only one valid is high, that requester gets ready.
  - If both are high, round-robin: grant goes to the requester not in last_grant.
  - Ready is never high outside IDLE, and never for both requesters in the same cycle.
- Acceptance (valid & ready at rising edge E0):
  - The input is captured into a shadow register; the input may change afterwards.
  - The beat counter clears to 0, the FSM enters RUN_ST or RUN_KW, and last_grant is updated.
- Each RUN cycle with beat b:
  - Shadow bytes b*LANES .. b*LANES+LANES-1 go through the S-box lanes.
  - Results are written into the same byte positions of the result register at the next edge; the counter increments.
- Completion:
  - At edge E_B (B = ST_BEATS or KW_BEATS), the last beat is written, the result is copied to st_out / kw_out, the matching out_valid is set for one cycle, and the FSM returns to IDLE.
  - Latency is B+1 edges from acceptance to out_valid.
  - A new request can be accepted at E_{B+1}, while out_valid is still high. Throughput is one job per B+1 cycles.
- Output holding:
  - st_out / kw_out hold their value until that requester's next job completes.
  - A job for the other requester never disturbs them.
- A valid dropped before acceptance is legal and is simply not served. No valid-stability rule is imposed.
- Jobs are non-preemptive: a pending request waits until the running job completes, then arbitration applies.
- Unused lanes (key-word job with LANES>4) are ignored; their result bytes are not written.

Test Plan:
- State SubBytes, LANES=4:
  - Stimulus: st_in=00112233445566778899AABBCCDDEEFF.
  - Required: st_out=638293C31BFC33F5C4EEACEA4BC12816 with st_out_valid high exactly 5 cycles after acceptance; busy high for 4 cycles.
- Key word SubWord:
  - Stimulus: kw_in=09CF4F3C.
  - Required: kw_out=018A84EB, kw_out_valid 2 cycles after acceptance (LANES=4); st_out is unchanged.
- Simultaneous requests after reset:
  - Stimulus: both valids high.
  - Required order: key word first, then state, then key word again if both stay asserted (round-robin alternation); ready is never high for both in one cycle.
- Back-to-back:
  - Stimulus: st_req_valid held high with a new st_in each accepted job.
  - Required: accepted every 5 cycles, and each out_valid pulse carries the matching result.
- Reset mid-job:
  - Stimulus: reset_n low during beat 2 of a state job.
  - Required: all outputs 0 immediately; after release, no stale out_valid; the next request completes correctly.
- Sweep LANES=1, 2, 8, 16 with the same vectors:
  - Required latency 17/9/3/2 edges for a state job and 5/3/2/2 for a key word; identical results in every case.

Source files
------------

// File: rtl/sbox_scheduler.sv
// Shares LANES combinational AES S-boxes between a 128-bit SubBytes
// requester and a 32-bit SubWord requester, LANES bytes per cycle.
module sbox_scheduler #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_in,
  output logic [127:0] st_out,
  output logic         st_out_valid,
  input  logic         kw_req_valid,
  output logic         kw_req_ready,
  input  logic [31:0]  kw_in,
  output logic [31:0]  kw_out,
  output logic         kw_out_valid,
  output logic         busy
);

  localparam int ST_BEATS = 16 / LANES;
  localparam int KW_BEATS = (LANES > 4) ? 1 : 4 / LANES;

  typedef enum logic [1:0] {
    IDLE,
    RUN_ST,
    RUN_KW
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   beat_q, beat_d;
  logic         lg_st_q, lg_st_d;
  logic [127:0] sh_q, sh_d;
  logic [127:0] res_q, res_d;
  logic [127:0] st_out_q, st_out_d;
  logic [31:0]  kw_out_q, kw_out_d;
  logic         st_v_q, st_v_d;
  logic         kw_v_q, kw_v_d;
  logic         st_rdy, kw_rdy;
  logic [127:0] res_m;
  int           idx;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  // GF(2^8) inverse as a^254, then the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  endfunction

  assign kw_rdy = (state_q == IDLE) && kw_req_valid
                  && (!st_req_valid || lg_st_q);
  assign st_rdy = (state_q == IDLE) && st_req_valid
                  && !kw_rdy;

  // Key words live in the top 32 bits of the shared shadow/result.
  always_comb begin
    res_m = res_q;
    idx   = 0;
    for (int l = 0; l < LANES; l++) begin
      idx = (int'(beat_q) * LANES + l) % 16;
      if (!(state_q == RUN_KW && l >= 4)) begin
        res_m[127-8*idx -: 8] = sbox(sh_q[127-8*idx -: 8]);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    lg_st_d  = lg_st_q;
    sh_d     = sh_q;
    res_d    = res_q;
    st_out_d = st_out_q;
    kw_out_d = kw_out_q;
    st_v_d   = 1'b0;
    kw_v_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (st_rdy) begin
          sh_d    = st_in;
          beat_d  = '0;
          lg_st_d = 1'b1;
          state_d = RUN_ST;
        end else if (kw_rdy) begin
          sh_d    = {kw_in, 96'h0};
          beat_d  = '0;
          lg_st_d = 1'b0;
          state_d = RUN_KW;
        end
      end
      RUN_ST: begin
        res_d  = res_m;
        beat_d = beat_q + 4'd1;
        if (beat_q == 4'(ST_BEATS - 1)) begin
          st_out_d = res_m;
          st_v_d   = 1'b1;
          beat_d   = '0;
          state_d  = IDLE;
        end
      end
      RUN_KW: begin
        res_d  = res_m;
        beat_d = beat_q + 4'd1;
        if (beat_q == 4'(KW_BEATS - 1)) begin
          kw_out_d = res_m[127:96];
          kw_v_d   = 1'b1;
          beat_d   = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      lg_st_q  <= 1'b1;
      sh_q     <= '0;
      res_q    <= '0;
      st_out_q <= '0;
      kw_out_q <= '0;
      st_v_q   <= 1'b0;
      kw_v_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      lg_st_q  <= lg_st_d;
      sh_q     <= sh_d;
      res_q    <= res_d;
      st_out_q <= st_out_d;
      kw_out_q <= kw_out_d;
      st_v_q   <= st_v_d;
      kw_v_q   <= kw_v_d;
    end
  end

  assign st_req_ready = st_rdy;
  assign kw_req_ready = kw_rdy;
  assign st_out       = st_out_q;
  assign kw_out       = kw_out_q;
  assign st_out_valid = st_v_q;
  assign kw_out_valid = kw_v_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_scheduler.sv
// Bench for sbox_scheduler: five instances (LANES 1..16) on shared
// inputs; instance 2 (LANES=4) drives the handshake tests.
module tb_sbox_scheduler;

  localparam int NI = 5;
  localparam int MI = 2;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         st_req_valid = 1'b0;
  logic         kw_req_valid = 1'b0;
  logic [127:0] st_in = '0;
  logic [31:0]  kw_in = '0;

  logic         st_rdy_w [NI];
  logic         kw_rdy_w [NI];
  logic [127:0] st_out_w [NI];
  logic [31:0]  kw_out_w [NI];
  logic         st_ov_w  [NI];
  logic         kw_ov_w  [NI];
  logic         busy_w   [NI];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sbox_scheduler #(.LANES(1 << g)) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .st_req_valid (st_req_valid),
      .st_req_ready (st_rdy_w[g]),
      .st_in        (st_in),
      .st_out       (st_out_w[g]),
      .st_out_valid (st_ov_w[g]),
      .kw_req_valid (kw_req_valid),
      .kw_req_ready (kw_rdy_w[g]),
      .kw_in        (kw_in),
      .kw_out       (kw_out_w[g]),
      .kw_out_valid (kw_ov_w[g]),
      .busy         (busy_w[g])
    );
  end

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047-8*int'(b) -: 8];
  endfunction

  function automatic logic [127:0] ref_st(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sb(x[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [31:0] ref_kw(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[31-8*i -: 8] = sb(x[31-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int st_beats(input int l);
    return 16 / l;
  endfunction

  function automatic int kw_beats(input int l);
    return (l > 4) ? 1 : 4 / l;
  endfunction

  // Drives one request on the LANES=4 instance and waits for its pulse.
  task automatic run_job(
    input  bit           kw,
    input  logic [127:0] d,
    output int           lat,
    output int           busy_n,
    output bit           ok
  );
    int w;
    ok = 1'b0;
    lat = 0;
    busy_n = 0;
    @(negedge clk);
    if (kw) begin
      kw_req_valid = 1'b1;
      kw_in = d[31:0];
    end else begin
      st_req_valid = 1'b1;
      st_in = d;
    end
    #1;
    for (w = 0; w < 20; w++) begin
      if (kw ? kw_rdy_w[MI] : st_rdy_w[MI]) break;
      @(negedge clk);
      #1;
    end
    if (w == 20) begin
      st_req_valid = 1'b0;
      kw_req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    st_req_valid = 1'b0;
    kw_req_valid = 1'b0;
    st_in = rnd128();
    kw_in = $urandom;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (busy_w[MI]) busy_n++;
      if (kw ? kw_ov_w[MI] : st_ov_w[MI]) begin
        lat = k;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    st_req_valid = 1'b0;
    kw_req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      n_tests++;
      if (st_out_w[i] !== '0 || kw_out_w[i] !== '0 || st_ov_w[i] !== 1'b0
          || kw_ov_w[i] !== 1'b0 || busy_w[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_%0d st_out=%h kw_out=%h ov=%b%b busy=%b want all 0",
                 i, st_out_w[i], kw_out_w[i], st_ov_w[i], kw_ov_w[i], busy_w[i]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_st_known();
    int lat, bn;
    bit ok;
    logic [127:0] exp;
    exp = 128'h638293C31BFC33F5C4EEACEA4BC12816;
    run_job(1'b0, 128'h00112233445566778899AABBCCDDEEFF, lat, bn, ok);
    n_tests++;
    if (!ok || st_out_w[MI] !== exp) begin
      n_fail++;
      $display("FAIL st_known got %h ok=%0d want %h", st_out_w[MI], ok, exp);
    end
    n_tests++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL st_latency got %0d want 5", lat);
    end
    n_tests++;
    if (bn != 4) begin
      n_fail++;
      $display("FAIL st_busy_cycles got %0d want 4", bn);
    end
    @(negedge clk);
    n_tests++;
    if (st_ov_w[MI] !== 1'b0) begin
      n_fail++;
      $display("FAIL st_pulse_width got %b want 0", st_ov_w[MI]);
    end
  endtask

  task automatic test_kw_known();
    int lat, bn;
    bit ok;
    logic [127:0] st_prev;
    st_prev = st_out_w[MI];
    run_job(1'b1, 128'h09CF4F3C, lat, bn, ok);
    n_tests++;
    if (!ok || kw_out_w[MI] !== 32'h018A84EB) begin
      n_fail++;
      $display("FAIL kw_known got %h ok=%0d want 018a84eb", kw_out_w[MI], ok);
    end
    n_tests++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL kw_latency got %0d want 2", lat);
    end
    n_tests++;
    if (st_out_w[MI] !== st_prev) begin
      n_fail++;
      $display("FAIL kw_keeps_st got %h want %h", st_out_w[MI], st_prev);
    end
  endtask

  task automatic test_simultaneous();
    int acc[$];
    int st_seen, kw_seen, both;
    logic [127:0] st_d;
    logic [31:0] kw_d;
    do_reset();
    st_seen = 0;
    kw_seen = 0;
    both = 0;
    st_d = rnd128();
    kw_d = $urandom;
    @(negedge clk);
    st_in = st_d;
    kw_in = kw_d;
    st_req_valid = 1'b1;
    kw_req_valid = 1'b1;
    #1;
    for (int c = 0; c < 60 && acc.size() < 3; c++) begin
      if (st_rdy_w[MI] && kw_rdy_w[MI]) both++;
      if (kw_rdy_w[MI]) acc.push_back(1);
      else if (st_rdy_w[MI]) acc.push_back(0);
      @(negedge clk);
      if (st_ov_w[MI]) begin
        st_seen++;
        n_tests++;
        if (st_out_w[MI] !== ref_st(st_d)) begin
          n_fail++;
          $display("FAIL rr_st_data got %h want %h", st_out_w[MI], ref_st(st_d));
        end
      end
      if (kw_ov_w[MI]) begin
        kw_seen++;
        n_tests++;
        if (kw_out_w[MI] !== ref_kw(kw_d)) begin
          n_fail++;
          $display("FAIL rr_kw_data got %h want %h", kw_out_w[MI], ref_kw(kw_d));
        end
      end
      #1;
    end
    st_req_valid = 1'b0;
    kw_req_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (kw_ov_w[MI]) begin
        kw_seen++;
        n_tests++;
        if (kw_out_w[MI] !== ref_kw(kw_d)) begin
          n_fail++;
          $display("FAIL rr_kw_data got %h want %h", kw_out_w[MI], ref_kw(kw_d));
        end
      end
      if (st_ov_w[MI]) st_seen++;
    end
    n_tests++;
    if (both != 0) begin
      n_fail++;
      $display("FAIL rr_both_ready got %0d cycles want 0", both);
    end
    n_tests++;
    if (acc.size() != 3 || acc[0] != 1 || acc[1] != 0 || acc[2] != 1) begin
      n_fail++;
      $display("FAIL rr_order got n=%0d %p want kw,st,kw (1,0,1)", acc.size(), acc);
    end
    n_tests++;
    if (st_seen != 1 || kw_seen != 2) begin
      n_fail++;
      $display("FAIL rr_pulses got st=%0d kw=%0d want st=1 kw=2", st_seen, kw_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_q[$];
    int acc_c[$];
    int cyc, seen, n_acc;
    bit accepted;
    logic [127:0] e;
    cyc = 0;
    seen = 0;
    n_acc = 0;
    @(negedge clk);
    st_in = rnd128();
    st_req_valid = 1'b1;
    #1;
    while (cyc < 100 && seen < 6) begin
      accepted = st_rdy_w[MI];
      if (accepted) begin
        exp_q.push_back(ref_st(st_in));
        acc_c.push_back(cyc);
        n_acc++;
      end
      @(negedge clk);
      cyc++;
      if (st_ov_w[MI]) begin
        seen++;
        n_tests++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (st_out_w[MI] !== e) begin
          n_fail++;
          $display("FAIL b2b_data job %0d got %h want %h", seen, st_out_w[MI], e);
        end
      end
      if (accepted) begin
        if (n_acc < 6) st_in = rnd128();
        else st_req_valid = 1'b0;
      end
      #1;
    end
    st_req_valid = 1'b0;
    n_tests++;
    if (seen != 6) begin
      n_fail++;
      $display("FAIL b2b_jobs got %0d want 6", seen);
    end
    for (int i = 1; i < acc_c.size(); i++) begin
      n_tests++;
      if (acc_c[i] - acc_c[i-1] != 5) begin
        n_fail++;
        $display("FAIL b2b_spacing got %0d want 5", acc_c[i] - acc_c[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w, stale, lat, bn;
    bit ok;
    logic [127:0] d;
    @(negedge clk);
    st_in = rnd128();
    st_req_valid = 1'b1;
    #1;
    for (w = 0; w < 20 && !st_rdy_w[MI]; w++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    st_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (w == 20 || busy_w[MI] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy got %b want 1", busy_w[MI]);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (st_out_w[MI] !== '0 || kw_out_w[MI] !== '0 || busy_w[MI] !== 1'b0
        || st_ov_w[MI] !== 1'b0 || kw_ov_w[MI] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_clear st=%h kw=%h busy=%b want 0",
               st_out_w[MI], kw_out_w[MI], busy_w[MI]);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (st_ov_w[MI] || kw_ov_w[MI] || busy_w[MI]) stale++;
    end
    n_tests++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL mid_stale got %0d active cycles want 0", stale);
    end
    d = rnd128();
    run_job(1'b0, d, lat, bn, ok);
    n_tests++;
    if (!ok || st_out_w[MI] !== ref_st(d) || lat != 5) begin
      n_fail++;
      $display("FAIL mid_recover got %h lat=%0d want %h lat=5",
               st_out_w[MI], lat, ref_st(d));
    end
  endtask

  task automatic test_random();
    int lat, bn;
    bit ok, kw;
    logic [127:0] d, st_exp;
    logic [31:0] kw_exp;
    st_exp = st_out_w[MI];
    kw_exp = kw_out_w[MI];
    for (int j = 0; j < 10; j++) begin
      kw = 1'($urandom_range(0, 1));
      d = rnd128();
      run_job(kw, d, lat, bn, ok);
      if (kw) kw_exp = ref_kw(d[31:0]);
      else st_exp = ref_st(d);
      n_tests++;
      if (!ok || st_out_w[MI] !== st_exp || kw_out_w[MI] !== kw_exp
          || lat != (kw ? 2 : 5)) begin
        n_fail++;
        $display("FAIL rand_%0d kw=%0d st=%h kw_out=%h lat=%0d want %h %h %0d",
                 j, kw, st_out_w[MI], kw_out_w[MI], lat, st_exp, kw_exp, kw ? 2 : 5);
      end
    end
  endtask

  task automatic test_lanes_sweep();
    int lat [NI];
    logic [127:0] d;
    int nr, exp_lat;
    bit kw;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      kw = r[0];
      if (r == 0) d = 128'h00112233445566778899AABBCCDDEEFF;
      else if (r == 1) d = 128'h09CF4F3C;
      else d = rnd128();
      @(negedge clk);
      if (kw) begin
        kw_in = d[31:0];
        kw_req_valid = 1'b1;
      end else begin
        st_in = d;
        st_req_valid = 1'b1;
      end
      #1;
      nr = 0;
      for (int i = 0; i < NI; i++) if (kw ? kw_rdy_w[i] : st_rdy_w[i]) nr++;
      n_tests++;
      if (nr != NI) begin
        n_fail++;
        $display("FAIL sweep_ready round %0d got %0d ready want %0d", r, nr, NI);
      end
      for (int i = 0; i < NI; i++) lat[i] = 0;
      @(negedge clk);
      st_req_valid = 1'b0;
      kw_req_valid = 1'b0;
      st_in = rnd128();
      kw_in = $urandom;
      for (int k = 1; k <= 25; k++) begin
        if (k > 1) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
          if (lat[i] == 0 && (kw ? kw_ov_w[i] : st_ov_w[i])) begin
            lat[i] = k;
            n_tests++;
            if (kw ? (kw_out_w[i] !== ref_kw(d[31:0])) : (st_out_w[i] !== ref_st(d))) begin
              n_fail++;
              $display("FAIL sweep_data L=%0d kw=%0d st=%h kw_out=%h want %h %h",
                       1 << i, kw, st_out_w[i], kw_out_w[i], ref_st(d), ref_kw(d[31:0]));
            end
          end
        end
      end
      for (int i = 0; i < NI; i++) begin
        exp_lat = (kw ? kw_beats(1 << i) : st_beats(1 << i)) + 1;
        n_tests++;
        if (lat[i] != exp_lat) begin
          n_fail++;
          $display("FAIL sweep_latency L=%0d kw=%0d got %0d want %0d",
                   1 << i, kw, lat[i], exp_lat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_st_known();
    test_kw_known();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_lanes_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
